// File: rtl/switch_egress_port.sv
// switch_egress_port: egress side of one port of the 4-port switch.
// Round-robin arbitration over the four ingress FIFO heads, misroute
// filtering, a single output register with valid/ready backpressure,
// and transmit/drop statistics.
//
// Handshake: a word moves downstream on a rising edge where valid_out and
// out_ready are both high. valid_out and the output word stay unchanged
// until that happens. Ingress FIFOs pop on the edge where their grant bit is
// high. They hold their head packet while not granted.
module switch_egress_port #(
    parameter int PORT_ID = 0,
    parameter int DATA_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req_valid,
    input  logic [15:0]         req_source,
    input  logic [15:0]         req_target,
    input  logic [4*DATA_W-1:0] req_data,
    output logic [3:0]          grant,
    input  logic                out_ready,
    output logic                valid_out,
    output logic [3:0]          source_out,
    output logic [3:0]          target_out,
    output logic [DATA_W-1:0]   data_out,
    output logic                err_misroute,
    output logic [15:0]         tx_count,
    output logic [7:0]          drop_count
);

    // The output register state is visible directly as valid_out.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q;
    logic [1:0]          rr_ptr;
    logic [1:0]          win_idx;
    logic [1:0]          scan_idx;
    logic                win_found;
    logic                can_load;
    logic                arb_en;
    logic                transfer;
    logic                hit;
    logic [3:0]          win_source;
    logic [3:0]          win_target;
    logic [DATA_W-1:0]   win_data;

    assign valid_out = (state_q == FULL);
    assign transfer  = valid_out && out_ready;
    assign can_load  = !valid_out || out_ready;
    assign arb_en    = !rst && can_load && (req_valid != 4'b0000);

    // Round-robin search: first requester at or after rr_ptr wins.
    always_comb begin
        win_idx   = 2'd0;
        win_found = 1'b0;
        scan_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr + 2'(k);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Select the winner's fields and decide whether it belongs on this port.
    always_comb begin
        win_source = req_source[win_idx*4 +: 4];
        win_target = req_target[win_idx*4 +: 4];
        win_data   = req_data[win_idx*DATA_W +: DATA_W];
        hit        = win_target[PORT_ID];
    end

    // Pop strobe to the winning ingress FIFO (zero during reset or backpressure).
    always_comb begin
        grant = 4'b0000;
        if (arb_en && win_found) begin
            grant = 4'b0001 << win_idx;
        end
    end

    // Output register, round-robin pointer, misroute pulse and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            source_out   <= 4'd0;
            target_out   <= 4'd0;
            data_out     <= '0;
            err_misroute <= 1'b0;
            tx_count     <= 16'd0;
            drop_count   <= 8'd0;
            rr_ptr       <= 2'd0;
        end else begin
            err_misroute <= 1'b0;
            if (transfer) begin
                tx_count <= tx_count + 16'd1;
                state_q  <= EMPTY;
            end
            if (arb_en && win_found) begin
                rr_ptr <= win_idx + 2'd1;
                if (hit) begin
                    // Load may overwrite the word leaving on this same edge.
                    state_q    <= FULL;
                    source_out <= win_source;
                    target_out <= win_target;
                    data_out   <= win_data;
                end else begin
                    err_misroute <= 1'b1;
                    if (drop_count != 8'hFF) begin
                        drop_count <= drop_count + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_egress_port.sv
// tb_switch_egress_port: directed test of switch_egress_port with PORT_ID=1.
module tb_switch_egress_port;

  localparam int DATA_W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]          req_valid = '0;
  logic [15:0]         req_source = '0;
  logic [15:0]         req_target = '0;
  logic [4*DATA_W-1:0] req_data = '0;
  logic [3:0]          grant;
  logic                out_ready = 1'b0;
  logic                valid_out;
  logic [3:0]          source_out;
  logic [3:0]          target_out;
  logic [DATA_W-1:0]   data_out;
  logic                err_misroute;
  logic [15:0]         tx_count;
  logic [7:0]          drop_count;

  int errors = 0;
  int checks = 0;

  switch_egress_port #(.PORT_ID(1), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_source   (req_source),
    .req_target   (req_target),
    .req_data     (req_data),
    .grant        (grant),
    .out_ready    (out_ready),
    .valid_out    (valid_out),
    .source_out   (source_out),
    .target_out   (target_out),
    .data_out     (data_out),
    .err_misroute (err_misroute),
    .tx_count     (tx_count),
    .drop_count   (drop_count)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] tgt, input logic [7:0] data);
    req_source[i*4 +: 4]         = 4'b0001 << i;
    req_target[i*4 +: 4]         = tgt;
    req_data[i*DATA_W +: DATA_W] = data;
  endtask

  // comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset: grant must stay low even with all requests present
    rst = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 4'b0010, 8'h10 + 8'(i));
    req_valid = 4'b1111;
    step();
    settle();
    check("grant_in_reset", 32'(grant), 'h0);
    step();
    check("reset_valid", 32'(valid_out), 'h0);
    check("reset_tx", 32'(tx_count), 'h0);
    check("reset_drop", 32'(drop_count), 'h0);
    check("reset_err", 32'(err_misroute), 'h0);

    // single packet from requester 0
    rst = 1'b0;
    req_valid = 4'b0001;
    set_req(0, 4'b0010, 8'hA5);
    out_ready = 1'b1;
    settle();
    check("single_grant", 32'(grant), 'h1);
    step();
    req_valid = 4'b0000;
    check("single_valid", 32'(valid_out), 'h1);
    check("single_data", 32'(data_out), 'hA5);
    check("single_source", 32'(source_out), 'h1);
    check("single_target", 32'(target_out), 'h2);
    check("single_tx_before", 32'(tx_count), 'h0);
    settle();
    check("single_no_grant", 32'(grant), 'h0);
    step();
    check("single_drained", 32'(valid_out), 'h0);
    check("single_tx", 32'(tx_count), 'h1);

    // all four requesting, rr_ptr=1: 0010, 0100, 1000, 0001, 0010
    set_req(0, 4'b0010, 8'h10);
    req_valid = 4'b1111;
    settle();
    check("rr_grant_1", 32'(grant), 'h2);
    step();
    check("rr_data_1", 32'(data_out), 'h11);
    settle();
    check("rr_grant_2", 32'(grant), 'h4);
    step();
    check("rr_data_2", 32'(data_out), 'h12);
    check("rr_valid_2", 32'(valid_out), 'h1);
    settle();
    check("rr_grant_3", 32'(grant), 'h8);
    step();
    check("rr_data_3", 32'(data_out), 'h13);
    settle();
    check("rr_grant_4", 32'(grant), 'h1);
    step();
    check("rr_data_4", 32'(data_out), 'h10);
    check("rr_source_4", 32'(source_out), 'h1);
    settle();
    check("rr_grant_5", 32'(grant), 'h2);
    step();
    check("rr_data_5", 32'(data_out), 'h11);
    check("rr_tx", 32'(tx_count), 'h5);

    // backpressure: no grant, word held for 5 cycles
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("bp_grant", 32'(grant), 'h0);
      step();
      check("bp_valid", 32'(valid_out), 'h1);
      check("bp_data", 32'(data_out), 'h11);
      check("bp_tx", 32'(tx_count), 'h5);
    end
    out_ready = 1'b1;
    settle();
    check("bp_release_grant", 32'(grant), 'h4);
    step();
    check("bp_release_tx", 32'(tx_count), 'h6);
    check("bp_release_data", 32'(data_out), 'h12);

    // drain, then a normal packet from requester 3 (rr_ptr 3 -> 0)
    req_valid = 4'b0000;
    step();
    check("drain_valid", 32'(valid_out), 'h0);
    check("drain_tx", 32'(tx_count), 'h7);
    set_req(3, 4'b0010, 8'h33);
    req_valid = 4'b1000;
    settle();
    check("r3_grant", 32'(grant), 'h8);
    step();
    check("r3_data", 32'(data_out), 'h33);

    // misroute from requester 2 while the held word transfers
    set_req(2, 4'b0100, 8'h22);
    req_valid = 4'b0100;
    settle();
    check("mis_grant", 32'(grant), 'h4);
    step();
    check("mis_err", 32'(err_misroute), 'h1);
    check("mis_drop", 32'(drop_count), 'h1);
    check("mis_valid", 32'(valid_out), 'h0);
    check("mis_tx", 32'(tx_count), 'h8);
    set_req(2, 4'b0010, 8'h22);
    req_valid = 4'b1111;
    settle();
    check("mis_next_grant", 32'(grant), 'h8);
    step();
    check("mis_err_clear", 32'(err_misroute), 'h0);
    check("mis_next_data", 32'(data_out), 'h33);
    check("mis_next_target", 32'(target_out), 'h2);

    // 300 misrouted packets: drop_count saturates
    for (int i = 0; i < 4; i++) set_req(i, 4'b0001, 8'h40 + 8'(i));
    for (int c = 0; c < 300; c++) step();
    check("sat_drop", 32'(drop_count), 'hFF);
    check("sat_err", 32'(err_misroute), 'h1);
    check("sat_valid", 32'(valid_out), 'h0);
    check("sat_tx", 32'(tx_count), 'h9);

    // multicast accepted, target passed unchanged; stream until tx wraps
    for (int i = 0; i < 4; i++) set_req(i, 4'b1011, 8'h50 + 8'(i));
    step();
    check("mc_valid", 32'(valid_out), 'h1);
    check("mc_target", 32'(target_out), 'hB);
    for (int c = 1; c < 65527; c++) step();
    check("wrap_max", 32'(tx_count), 'hFFFF);
    step();
    check("wrap_zero", 32'(tx_count), 'h0);
    step();
    check("wrap_one", 32'(tx_count), 'h1);
    check("wrap_drop_kept", 32'(drop_count), 'hFF);

    // reset while FULL with all requests present
    check("pre_rst_valid", 32'(valid_out), 'h1);
    rst = 1'b1;
    settle();
    check("rst_grant", 32'(grant), 'h0);
    step();
    check("rst_valid", 32'(valid_out), 'h0);
    check("rst_source", 32'(source_out), 'h0);
    check("rst_target", 32'(target_out), 'h0);
    check("rst_data", 32'(data_out), 'h0);
    check("rst_err", 32'(err_misroute), 'h0);
    check("rst_tx", 32'(tx_count), 'h0);
    check("rst_drop", 32'(drop_count), 'h0);
    check("rst_grant_held", 32'(grant), 'h0);
    rst = 1'b0;
    settle();
    check("post_rst_grant", 32'(grant), 'h1);
    step();
    check("post_rst_data", 32'(data_out), 'h50);
    check("post_rst_tx", 32'(tx_count), 'h0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // time limit
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/switch_egress_port.md
# switch_egress_port

Output-side port logic of the 4-port switch. It receives head-of-queue packets from the four ingress FIFOs that target this port, picks one per transfer with a round-robin arbiter, and pops the winning FIFO. The winning packet goes into an output register that drives `valid_out`/`source_out`/`target_out`/`data_out` under an `out_ready` backpressure handshake. It also drops misrouted packets and keeps transmit and drop statistics. One instance sits behind each of the four ports.

## Interface

- `PORT_ID`, default 0: index of this egress port (0..3). Target bit `PORT_ID` marks a packet for this port.
- `DATA_W`, default 8: payload width.
- `clk` in 1: single clock. All logic uses its rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `req_valid` in 4: bit i high means ingress FIFO i has a head packet requesting this port.
- `req_source` in 16: 4-bit one-hot source of requester i, at bits [4i+3:4i].
- `req_target` in 16: 4-bit one-hot target of requester i, at bits [4i+3:4i].
- `req_data` in 4*DATA_W: payload of requester i, at bits [DATA_W*i +: DATA_W].
- `grant` out 4: one-hot pop strobe to ingress FIFO i. Combinational, at most one bit high.
- `out_ready` in 1: downstream accepts the output word this cycle.
- `valid_out` out 1: output register holds a packet.
- `source_out` out 4: source of the held packet.
- `target_out` out 4: target of the held packet.
- `data_out` out DATA_W: payload of the held packet.
- `err_misroute` out 1: one-cycle pulse when a granted packet lacks target bit `PORT_ID`.
- `tx_count` out 16: count of transmitted packets. Wraps.
- `drop_count` out 8: count of misrouted packets. Saturates at 255.

## Operation

- Output register has two states. EMPTY means `valid_out`=0. FULL means `valid_out`=1.
- Transfer: `valid_out && out_ready` at a rising edge.
- Load enable: `can_load = !valid_out || out_ready`.
- Arbitration happens only when `can_load` is 1 and `req_valid` is nonzero.
- Round-robin pointer `rr_ptr` is 2 bits. Search order is rr_ptr, rr_ptr+1, ... mod 4. The first set `req_valid` bit wins, index w, and `grant[w]` is driven high.
- On the edge after a grant, `rr_ptr` becomes w+1 mod 4. This happens for both delivered and dropped packets.
- Misroute check: if `req_target[w]` bit `PORT_ID` is 0, the packet is popped but not loaded. `err_misroute` pulses for one cycle and `drop_count` increments, saturating at 255. A simultaneous transfer still completes: `valid_out` goes to 0 if the register was FULL and `out_ready` was high.
- Normal grant: `source_out`/`target_out`/`data_out` load from requester w and `valid_out` becomes 1. The load may replace a word transferred on the same edge, which gives back-to-back streaming.
- No grant while FULL and `out_ready` is 0. The output word and `valid_out` stay stable until a transfer (no-drop rule).
- A transfer with no new grant sets `valid_out` to 0.
- `tx_count` increments by 1 on every transfer and wraps from 65535 to 0.
- Multicast targets (several bits set) are accepted if bit `PORT_ID` is set. `target_out` passes the original target unchanged.
- `req_*` of a non-granted requester must be held by the ingress FIFO. This block never samples them.

## Timing

- Reset takes priority over everything on the same edge. It sets `valid_out`=0, `source_out`=0, `target_out`=0, `data_out`=0, `err_misroute`=0, `tx_count`=0, `drop_count`=0, `rr_ptr`=0.
- `grant` is 0 while `rst` is high.
- Reset during FULL discards the held packet. It is not counted.
- Latency: a request granted at edge N appears on `valid_out` after edge N (1 cycle).
- Throughput: one packet per cycle when `out_ready` is held high.
- `grant` is combinational from `req_valid`, `rr_ptr`, `valid_out` and `out_ready`. The ingress FIFO pops on the same edge.
- `err_misroute` is registered: high for exactly the cycle after the dropped grant.
- No combinational path from `req_*` to the `*_out` signals.

## Test plan

- Reset, then `req_valid`=0001, target=0010, `PORT_ID`=1, data=A5, `out_ready`=1 → `grant`=0001 in that cycle. Next cycle `valid_out`=1, data_out=A5, source_out=0001. `tx_count` reads 1 one cycle later.
- All four requests held continuously, `out_ready`=1 → grant sequence 0001, 0010, 0100, 1000, 0001. One packet per cycle with no bubbles.
- Hold `out_ready`=0 for 5 cycles with `valid_out`=1 and `req_valid`=1111 → `grant`=0, output word unchanged. First `out_ready`=1 cycle: transfer and a new grant in the same cycle.
- Requester 2 with target=0100, `PORT_ID`=1 → `grant`=0100, `err_misroute` pulses one cycle, `drop_count` increments, `valid_out` stays 0. The next grant goes to requester 3 if it is requesting.
- 300 misrouted packets → `drop_count` stays at 255. 65537 transfers → `tx_count`=1.
- `rst` asserted while FULL with `req_valid`=1111 → next cycle all outputs and counters are 0 and `grant`=0. After release the first grant is 0001.
